// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store initiator.
package mem_pkg;

    // Access width encoding carried on req_size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_BAD  = 2'b11
    } mem_size_t;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } mau_state_t;

    // Clears the byte offset so the RAM always sees a word address.
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

    // A request that cannot be served as a single aligned word access.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: extracts/extends load data from a RAM word and
// merges right-justified store data into a RAM word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  mem_size_t   i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_wdata_rep;
    logic [3:0]  w_lane_sel;

    // Pick the addressed byte and halfword out of the word.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    // Sign/zero extension of the extracted lane; a full word passes through.
    always_comb begin
        o_load_data = '0;
        case (i_size)
            SIZE_BYTE: o_load_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_load_data = {{16{i_signed & w_half[15]}}, w_half};
            SIZE_WORD: o_load_data = i_word;
            default:   o_load_data = '0;
        endcase
    end

    // Replicate store data across lanes so each lane mux only needs a select.
    always_comb begin
        w_wdata_rep = i_wdata;
        case (i_size)
            SIZE_BYTE: w_wdata_rep = {4{i_wdata[7:0]}};
            SIZE_HALF: w_wdata_rep = {2{i_wdata[15:0]}};
            default:   w_wdata_rep = i_wdata;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign w_lane_sel[gi] = ((i_size == SIZE_BYTE) && (i_offset == LANE)) ||
                                    ((i_size == SIZE_HALF) && (i_offset[1] == LANE[1])) ||
                                    (i_size == SIZE_WORD);
            assign o_store_word[8*gi +: 8] = w_lane_sel[gi] ? w_wdata_rep[8*gi +: 8]
                                                            : i_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, aligned word accesses to
// the RAM, read-modify-write for byte and halfword stores.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        ram_write_enable,
    output logic [31:0] ram_address,
    output logic [31:0] ram_in,
    input  logic [31:0] ram_out
);

    mau_state_t  r_state;
    mau_state_t  w_state_next;

    logic        r_write;
    logic        r_signed;
    mem_size_t   r_size;
    logic [1:0]  r_offset;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_addr;
    logic [31:0] r_rdata;
    logic        r_misaligned;

    mem_size_t   w_req_size;
    logic        w_accept;
    logic        w_req_misaligned;
    logic [31:0] w_align_word;
    logic [31:0] w_load_data;
    logic [31:0] w_store_word;

    assign w_req_size       = mem_size_t'(req_size);
    assign w_accept         = (r_state == IDLE) && req_valid;
    assign w_req_misaligned = is_misaligned(w_req_size, req_address[1:0]);
    // Load extraction works on live RAM data in READ; the merge uses the latched word.
    assign w_align_word     = (r_state == READ) ? ram_out : r_word;

    mem_lane_align u_lane_align (
        .i_word       (w_align_word),
        .i_offset     (r_offset),
        .i_size       (r_size),
        .i_signed     (r_signed),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_misaligned)
                        w_state_next = RESP;
                    else if (req_write && (w_req_size == SIZE_WORD))
                        w_state_next = WRITE;
                    else
                        w_state_next = READ;
                end
            end
            READ:    w_state_next = r_write ? WRITE : RESP;
            WRITE:   w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Request capture on acceptance, RAM word latch and load result in READ.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write      <= 1'b0;
            r_signed     <= 1'b0;
            r_size       <= SIZE_BYTE;
            r_offset     <= 2'b00;
            r_wdata      <= '0;
            r_word       <= '0;
            r_addr       <= '0;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
        end else if (w_accept) begin
            r_write      <= req_write;
            r_signed     <= req_signed;
            r_size       <= w_req_size;
            r_offset     <= req_address[1:0];
            r_wdata      <= req_wdata;
            r_addr       <= word_align(req_address);
            r_rdata      <= '0;
            r_misaligned <= w_req_misaligned;
        end else if (r_state == READ) begin
            r_word <= ram_out;
            if (!r_write)
                r_rdata <= w_load_data;
        end
    end

    assign req_ready        = (r_state == IDLE);
    assign resp_valid       = (r_state == RESP);
    assign ram_write_enable = (r_state == WRITE);
    assign ram_address      = r_addr;
    assign ram_in           = (r_state == WRITE) ? w_store_word : '0;
    assign resp_rdata       = r_rdata;
    assign resp_misaligned  = r_misaligned;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural RAM.
module tb_mem_access_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        ram_write_enable;
    logic [31:0] ram_address;
    logic [31:0] ram_in;
    logic [31:0] ram_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // RAM model: combinational read, word write on the rising edge,
    // plus a bench-side preload port.
    logic [31:0] mem [0:15];
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;

    assign ram_out = mem[ram_address[5:2]];

    always @(posedge clock) begin
        if (ram_write_enable)
            mem[ram_address[5:2]] <= ram_in;
        else if (pl_en)
            mem[pl_idx] <= pl_data;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mem_access_unit dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_address      (req_address),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_misaligned  (resp_misaligned),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_in           (ram_in),
        .ram_out          (ram_out)
    );

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clock);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    // Issue one request and observe cycles N+1..N+6 after the accept edge N.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int resp_cyc, output logic [7:0] we_mask,
                           output logic [31:0] rdata, output logic mis,
                           output logic [31:0] win, output logic [31:0] waddr);
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_address = a; req_wdata = wd;
        @(posedge clock); #1;
        req_valid = 1'b0;
        resp_cyc = -1; we_mask = '0; rdata = '0; mis = 1'b0; win = '0; waddr = '0;
        for (int k = 1; k <= 6; k++) begin
            if (ram_write_enable) begin
                we_mask[k] = 1'b1; win = ram_in; waddr = ram_address;
            end
            if (resp_valid && resp_cyc < 0) begin
                resp_cyc = k; rdata = resp_rdata; mis = resp_misaligned;
            end
            @(posedge clock); #1;
        end
        $display("txn w=%0b size=%0d signed=%0b addr=%h wdata=%h -> resp_cyc=%0d rdata=%h mis=%0b we_mask=%b",
                 w, sz, sg, a, wd, resp_cyc, rdata, mis, we_mask);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
        n_cmp++; if (resp_misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_misaligned got=%b exp=0", resp_misaligned); end
        n_cmp++; if (ram_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", ram_write_enable); end
        n_cmp++; if (ram_address !== 32'h0) begin n_fail++; $display("FAIL reset_ram_address got=%h exp=0", ram_address); end
        n_cmp++; if (ram_in !== 32'h0) begin n_fail++; $display("FAIL reset_ram_in got=%h exp=0", ram_in); end
        @(negedge clock); reset_n = 1'b1;
    endtask

    task automatic test_load_word;
        int c; logic [7:0] we; logic [31:0] rd, wi, wa; logic m;
        preload(4'd1, 32'h8899AABB);
        run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, c, we, rd, m, wi, wa);
        n_cmp++; if (c !== 2) begin n_fail++; $display("FAIL lw_latency got=%0d exp=2", c); end
        n_cmp++; if (rd !== 32'h8899AABB) begin n_fail++; $display("FAIL lw_rdata got=%h exp=8899aabb", rd); end
        n_cmp++; if (m !== 1'b0) begin n_fail++; $display("FAIL lw_misaligned got=%b exp=0", m); end
        n_cmp++; if (we !== 8'h0) begin n_fail++; $display("FAIL lw_no_write got=%b exp=00000000", we); end
    endtask

    task automatic test_load_sub;
        logic [1:0]  sz [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        logic        sg [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ad [6] = '{32'h6, 32'h6, 32'h6, 32'h4, 32'h4, 32'h7};
        logic [31:0] ex [6] = '{32'hFFFFFF99, 32'h00000099, 32'h00008899,
                                32'hFFFFAABB, 32'hFFFFFFBB, 32'h00000088};
        int c; logic [7:0] we; logic [31:0] rd, wi, wa; logic m;
        for (int i = 0; i < 6; i++) begin
            run_req(1'b0, sz[i], sg[i], ad[i], 32'h0, c, we, rd, m, wi, wa);
            n_cmp++; if (rd !== ex[i]) begin n_fail++; $display("FAIL load_sub_%0d_rdata got=%h exp=%h", i, rd, ex[i]); end
            n_cmp++; if (c !== 2) begin n_fail++; $display("FAIL load_sub_%0d_latency got=%0d exp=2", i, c); end
        end
    endtask

    task automatic test_store_byte;
        int c; logic [7:0] we; logic [31:0] rd, wi, wa; logic m;
        preload(4'd1, 32'h8899AABB);
        run_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h000000CC, c, we, rd, m, wi, wa);
        n_cmp++; if (we !== 8'b0000_0100) begin n_fail++; $display("FAIL sb_we_cycles got=%b exp=00000100", we); end
        n_cmp++; if (wa !== 32'h4) begin n_fail++; $display("FAIL sb_ram_address got=%h exp=00000004", wa); end
        n_cmp++; if (wi !== 32'h8899CCBB) begin n_fail++; $display("FAIL sb_ram_in got=%h exp=8899ccbb", wi); end
        n_cmp++; if (c !== 3) begin n_fail++; $display("FAIL sb_latency got=%0d exp=3", c); end
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sb_rdata got=%h exp=0", rd); end
        n_cmp++; if (mem[1] !== 32'h8899CCBB) begin n_fail++; $display("FAIL sb_ram_word got=%h exp=8899ccbb", mem[1]); end
    endtask

    task automatic test_store_half_word;
        int c; logic [7:0] we; logic [31:0] rd, wi, wa; logic m;
        preload(4'd1, 32'h8899AABB);
        run_req(1'b1, 2'b01, 1'b0, 32'h6, 32'h00001234, c, we, rd, m, wi, wa);
        n_cmp++; if (mem[1] !== 32'h1234AABB) begin n_fail++; $display("FAIL sh_ram_word got=%h exp=1234aabb", mem[1]); end
        n_cmp++; if (c !== 3) begin n_fail++; $display("FAIL sh_latency got=%0d exp=3", c); end
        run_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, c, we, rd, m, wi, wa);
        n_cmp++; if (rd !== 32'h00001234) begin n_fail++; $display("FAIL sh_readback got=%h exp=00001234", rd); end
        // Upper store-data bits must not leak into other lanes.
        run_req(1'b1, 2'b00, 1'b0, 32'h4, 32'hFFFFFF77, c, we, rd, m, wi, wa);
        n_cmp++; if (mem[1] !== 32'h1234AA77) begin n_fail++; $display("FAIL sb_lane0_word got=%h exp=1234aa77", mem[1]); end
        run_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, c, we, rd, m, wi, wa);
        n_cmp++; if (we !== 8'b0000_0010) begin n_fail++; $display("FAIL sw_we_cycles got=%b exp=00000010", we); end
        n_cmp++; if (c !== 2) begin n_fail++; $display("FAIL sw_latency got=%0d exp=2", c); end
        run_req(1'b0, 2'b10, 1'b1, 32'h8, 32'h0, c, we, rd, m, wi, wa);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_readback got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_misaligned;
        logic        w  [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad [3] = '{32'h5, 32'h3, 32'h0};
        int c; logic [7:0] we; logic [31:0] rd, wi, wa; logic m;
        preload(4'd0, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            run_req(w[i], sz[i], 1'b1, ad[i], 32'hFFFFFFFF, c, we, rd, m, wi, wa);
            n_cmp++; if (c !== 1) begin n_fail++; $display("FAIL mis_%0d_latency got=%0d exp=1", i, c); end
            n_cmp++; if (m !== 1'b1) begin n_fail++; $display("FAIL mis_%0d_flag got=%b exp=1", i, m); end
            n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mis_%0d_rdata got=%h exp=0", i, rd); end
            n_cmp++; if (we !== 8'h0) begin n_fail++; $display("FAIL mis_%0d_we got=%b exp=00000000", i, we); end
        end
        n_cmp++; if (mem[0] !== 32'h11223344) begin n_fail++; $display("FAIL mis_ram_word got=%h exp=11223344", mem[0]); end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        preload(4'd1, 32'h8899AABB);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_address = 32'h4; req_wdata = 32'h0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clock); #1;
            if (resp_valid) begin
                pulses++;
                n_cmp++; if (resp_rdata !== 32'h8899AABB) begin n_fail++; $display("FAIL b2b_rdata got=%h exp=8899aabb", resp_rdata); end
            end
        end
        req_valid = 1'b0;
        $display("txn back-to-back LW 0x4 held 9 cycles -> %0d responses", pulses);
        n_cmp++; if (pulses !== 3) begin n_fail++; $display("FAIL b2b_responses got=%0d exp=3", pulses); end
        repeat (3) @(posedge clock);
    endtask

    task automatic test_reset_mid_write;
        int seen = 0;
        int c; logic [7:0] we; logic [31:0] rd, wi, wa; logic m;
        preload(4'd1, 32'h8899AABB);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_address = 32'h5; req_wdata = 32'h000000CC;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        n_cmp++; if (ram_write_enable !== 1'b1) begin n_fail++; $display("FAIL rst_mid_we_before got=%b exp=1", ram_write_enable); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (ram_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_mid_we_drop got=%b exp=0", ram_write_enable); end
        @(posedge clock);
        @(negedge clock); reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            if (resp_valid) seen++;
        end
        $display("txn SB 0x5 reset during WRITE -> responses after reset=%0d ram=%h", seen, mem[1]);
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_resp got=%0d exp=0", seen); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
        n_cmp++; if (mem[1] !== 32'h8899AABB) begin n_fail++; $display("FAIL rst_mid_ram_word got=%h exp=8899aabb", mem[1]); end
        run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, c, we, rd, m, wi, wa);
        n_cmp++; if (rd !== 32'h8899AABB) begin n_fail++; $display("FAIL rst_mid_reload got=%h exp=8899aabb", rd); end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_address = '0; req_wdata = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        test_reset;
        test_load_word;
        test_load_sub;
        test_store_byte;
        test_store_half_word;
        test_misaligned;
        test_back_to_back;
        test_reset_mid_write;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the MIPS core's memory stage and the 32-bit byte-addressed, little-endian RAM. It accepts one byte, halfword or word load/store request at a time and issues aligned word accesses to the RAM. Sub-word loads are returned extracted and sign- or zero-extended. Sub-word stores use a read-modify-write sequence, because the RAM only writes whole words.

## Interface
Parameters: none.

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit idle; request accepted on edge with req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_address  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores/errors
- resp_misaligned  out  1  valid with resp_valid; alignment/size error
- ram_write_enable  out  1  RAM write strobe
- ram_address  out  32  always word-aligned ({addr[31:2],2'b00})
- ram_in  out  32  RAM write data
- ram_out  in  32  RAM combinational read data at ram_address

## Operation
- Request fields, including the aligned address and offset = addr[1:0], are registered on acceptance.
- Misaligned cases:
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
  - size 11
  - Any of these: no RAM access, resp_misaligned=1, resp_rdata=0.
- Byte lanes: the byte at offset k is bits [8k+7:8k]. A halfword at offset 0 is bits [15:0]; at offset 2 it is bits [31:16].
- FSM states are IDLE, READ, WRITE, RESP:
  - IDLE: req_ready=1. On accept: misaligned → RESP; SW → WRITE; SB/SH/loads → READ.
  - READ: drive ram_address; latch ram_out at the edge. Load → RESP; SB/SH → WRITE.
  - WRITE: ram_write_enable=1. ram_in = req_wdata for SW; otherwise the latched word with the target lane(s) replaced. → RESP.
  - RESP: resp_valid=1. → IDLE.
- Load result:
  - LW: latched word unchanged.
  - LB/LH: lane extracted, then sign-extended when req_signed=1, otherwise zero-extended.
  - req_signed is ignored for LW and for stores.
- req_valid is ignored outside IDLE. No request queueing.

## Timing
- The request is accepted at edge N. Responses:
  - Misaligned request: resp_valid in cycle N+1.
  - LW/LB/LH: READ in cycle N+1, resp_valid in cycle N+2.
  - SW: WRITE in cycle N+1 (RAM updated at its closing edge), resp_valid in cycle N+2.
  - SB/SH: READ in cycle N+1, WRITE in cycle N+2, resp_valid in cycle N+3.
- Minimum request spacing is 3 cycles (a load or SW with a request waiting at the RESP→IDLE edge).
- Derived outputs: req_ready and ram_write_enable are decoded combinationally from the state register. resp_rdata and resp_misaligned are registered.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_misaligned=0, ram_write_enable=0, ram_address=0, ram_in=0, all internal registers 0.
- Reset during an operation:
  - It drops ram_write_enable asynchronously, so no RAM write occurs at the next edge.
  - The in-flight request is discarded with no response.
  - A write already committed at an earlier edge stands.
- ram_address holds its value from acceptance through RESP.

## Structure
- Package mem_pkg holds:
  - mem_size_t enum: SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_BAD.
  - mau_state_t enum: IDLE, READ, WRITE, RESP.
  - A function or constant for the word-alignment mask.
- One combinational sub-module, mem_lane_align, takes word, offset, size, signed and wdata. It produces the extracted/extended load value and the merged store word. The FSM and registers stay in mem_access_unit.

## Test plan
- RAM word at 0x4 = 0x8899AABB; LW 0x4 → resp_valid at N+2, rdata 0x8899AABB, misaligned 0, no write.
- LB signed 0x6 → 0xFFFFFF99; LBU 0x6 → 0x00000099; LHU 0x6 → 0x00008899; LH signed 0x4 → 0xFFFFAABB.
- SB 0x5, wdata 0x000000CC, over 0x8899AABB → ram_write_enable high only in cycle N+2, ram_address 0x4, ram_in 0x8899CCBB, resp_valid at N+3.
- SH 0x6, wdata 0x00001234, then LH signed 0x6 → RAM word 0x1234AABB, load returns 0x00001234; SW 0x8, wdata 0xDEADBEEF → write in cycle N+1, readback 0xDEADBEEF.
- LW 0x5, SH 0x3 and size 11 at 0x0 → each gives resp_valid at N+1 with misaligned=1, rdata 0, and ram_write_enable never asserted.
- reset_n low mid-cycle during the WRITE state of SB 0x5 → ram_write_enable drops immediately, RAM stays 0x8899AABB, no resp_valid, req_ready=1 after release.
